// File: rtl/dds_seq_pkg.sv
// Shared types and helpers for the DDS preset sequencer: FSM states, config field
// selectors and the wrapping preset step.
package dds_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StReq
  } state_e;

  localparam logic [1:0] SelFrq  = 2'd0;
  localparam logic [1:0] SelPh   = 2'd1;
  localparam logic [1:0] SelAmp  = 2'd2;
  localparam logic [1:0] SelNone = 2'd3;

  function automatic int unsigned wrap_step(int unsigned idx, logic up, int unsigned depth);
    if (up) begin
      return (idx >= depth - 32'd1) ? 32'd0 : idx + 32'd1;
    end
    return (idx == 32'd0) ? depth - 32'd1 : idx - 32'd1;
  endfunction

endpackage

// File: rtl/dds_preset_bank.sv
// Preset table: NUM_PRESETS x NUM_CH frequency/phase/amplitude registers with a
// single config write port and a combinational read of one whole preset.
module dds_preset_bank
  import dds_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_PRESETS = 3,
  parameter int unsigned FRQ_W       = 32,
  parameter int unsigned PH_W        = 16,
  parameter int unsigned AMP_W       = 24,
  localparam int unsigned IDX_W      = $clog2(NUM_PRESETS),
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we_i,
  input  logic [IDX_W-1:0]          cfg_preset_i,
  input  logic [CH_W-1:0]           cfg_ch_i,
  input  logic [1:0]                cfg_sel_i,
  input  logic [31:0]               cfg_data_i,
  input  logic [IDX_W-1:0]          rd_idx_i,
  output logic                      wr_ok_o,
  output logic [NUM_CH*FRQ_W-1:0]   rd_frq_o,
  output logic [NUM_CH*PH_W-1:0]    rd_ph_o,
  output logic [NUM_CH*AMP_W-1:0]   rd_amp_o
);

  logic [FRQ_W-1:0] frq_q [NUM_PRESETS][NUM_CH];
  logic [FRQ_W-1:0] frq_d [NUM_PRESETS][NUM_CH];
  logic [PH_W-1:0]  ph_q  [NUM_PRESETS][NUM_CH];
  logic [PH_W-1:0]  ph_d  [NUM_PRESETS][NUM_CH];
  logic [AMP_W-1:0] amp_q [NUM_PRESETS][NUM_CH];
  logic [AMP_W-1:0] amp_d [NUM_PRESETS][NUM_CH];

  // Out-of-range indices and the unused selector drop the write entirely.
  assign wr_ok_o = cfg_we_i && (32'(cfg_preset_i) < NUM_PRESETS) &&
                   (32'(cfg_ch_i) < NUM_CH) && (cfg_sel_i != SelNone);

  always_comb begin
    frq_d = frq_q;
    ph_d  = ph_q;
    amp_d = amp_q;
    for (int unsigned p = 0; p < NUM_PRESETS; p++) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (wr_ok_o && (32'(cfg_preset_i) == p) && (32'(cfg_ch_i) == c)) begin
          unique case (cfg_sel_i)
            SelFrq:  frq_d[p][c] = FRQ_W'(cfg_data_i);
            SelPh:   ph_d[p][c]  = PH_W'(cfg_data_i);
            SelAmp:  amp_d[p][c] = AMP_W'(cfg_data_i);
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_frq_o = '0;
    rd_ph_o  = '0;
    rd_amp_o = '0;
    for (int unsigned p = 0; p < NUM_PRESETS; p++) begin
      if (32'(rd_idx_i) == p) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          rd_frq_o[c*FRQ_W +: FRQ_W] = frq_q[p][c];
          rd_ph_o[c*PH_W +: PH_W]    = ph_q[p][c];
          rd_amp_o[c*AMP_W +: AMP_W] = amp_q[p][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < NUM_PRESETS; p++) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          frq_q[p][c] <= '0;
          ph_q[p][c]  <= '0;
          amp_q[p][c] <= '0;
        end
      end
    end else begin
      frq_q <= frq_d;
      ph_q  <= ph_d;
      amp_q <= amp_d;
    end
  end

endmodule

// File: rtl/dds_preset_sequencer.sv
// Steps through the preset table on key pulses or the auto-dwell timer and hands each
// selected preset to the DDS driver over a valid/ready update handshake.
module dds_preset_sequencer
  import dds_seq_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned NUM_PRESETS = 3,
  parameter int unsigned FRQ_W       = 32,
  parameter int unsigned PH_W        = 16,
  parameter int unsigned AMP_W       = 24,
  parameter int unsigned DWELL_W     = 24,
  localparam int unsigned IDX_W      = $clog2(NUM_PRESETS),
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_next,
  input  logic                      key_prev,
  input  logic                      auto_en,
  input  logic [DWELL_W-1:0]        dwell,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_preset,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [1:0]                cfg_sel,
  input  logic [31:0]               cfg_data,
  output logic [NUM_CH*FRQ_W-1:0]   frq_o,
  output logic [NUM_CH*PH_W-1:0]    ph_o,
  output logic [NUM_CH*AMP_W-1:0]   amp_o,
  output logic                      upd_valid,
  input  logic                      upd_ready,
  output logic [IDX_W-1:0]          idx_o
);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          target_q, target_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      step_pend_q, step_pend_d;
  logic                      cfg_pend_q, cfg_pend_d;
  logic [DWELL_W-1:0]        cnt_q, cnt_d;
  logic                      settled_q, settled_d;
  logic                      upd_valid_q, upd_valid_d;
  logic [NUM_CH*FRQ_W-1:0]   frq_q, frq_d;
  logic [NUM_CH*PH_W-1:0]    ph_q, ph_d;
  logic [NUM_CH*AMP_W-1:0]   amp_q, amp_d;

  logic                      wr_ok;
  logic [NUM_CH*FRQ_W-1:0]   rd_frq;
  logic [NUM_CH*PH_W-1:0]    rd_ph;
  logic [NUM_CH*AMP_W-1:0]   rd_amp;

  dds_preset_bank #(
    .NUM_CH      (NUM_CH),
    .NUM_PRESETS (NUM_PRESETS),
    .FRQ_W       (FRQ_W),
    .PH_W        (PH_W),
    .AMP_W       (AMP_W)
  ) u_bank (
    .clk          (clk),
    .rst          (rst),
    .cfg_we_i     (cfg_we),
    .cfg_preset_i (cfg_preset),
    .cfg_ch_i     (cfg_ch),
    .cfg_sel_i    (cfg_sel),
    .cfg_data_i   (cfg_data),
    .rd_idx_i     (target_q),
    .wr_ok_o      (wr_ok),
    .rd_frq_o     (rd_frq),
    .rd_ph_o      (rd_ph),
    .rd_amp_o     (rd_amp)
  );

  logic key_ev, auto_run, auto_ev, step_ev, step_up, handshake, cfg_hit;
  logic [IDX_W-1:0] step_tgt;

  // The first IDLE cycle after a handshake is a return cycle and does not count as dwell.
  assign auto_run  = (state_q == StIdle) && settled_q && auto_en && (dwell != '0);
  assign key_ev    = key_next ^ key_prev;
  assign auto_ev   = auto_run && !(key_next || key_prev) && (cnt_q >= dwell - DWELL_W'(1));
  assign step_ev   = key_ev || auto_ev;
  assign step_up   = key_ev ? key_next : 1'b1;
  assign step_tgt  = IDX_W'(wrap_step(32'(target_q), step_up, NUM_PRESETS));
  assign handshake = upd_valid_q && upd_ready;
  // During LOAD the preset being captured is target_q, which idx_o is about to take.
  assign cfg_hit   = wr_ok && (cfg_preset == ((state_q == StLoad) ? target_q : idx_q));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    step_pend_d = step_pend_q;
    cfg_pend_d  = cfg_pend_q;
    upd_valid_d = upd_valid_q;
    frq_d       = frq_q;
    ph_d        = ph_q;
    amp_d       = amp_q;
    target_d    = step_ev ? step_tgt : target_q;

    unique case (state_q)
      StIdle: begin
        step_pend_d = 1'b0;
        cfg_pend_d  = 1'b0;
        if (step_ev || cfg_hit || step_pend_q || cfg_pend_q) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        frq_d       = rd_frq;
        ph_d        = rd_ph;
        amp_d       = rd_amp;
        idx_d       = target_q;
        upd_valid_d = 1'b1;
        step_pend_d = (target_d != target_q);
        cfg_pend_d  = cfg_hit;
        state_d     = StReq;
      end
      StReq: begin
        step_pend_d = (target_d != idx_q);
        cfg_pend_d  = cfg_pend_q || cfg_hit;
        if (handshake) begin
          upd_valid_d = 1'b0;
          state_d     = (step_pend_d || cfg_pend_d) ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    settled_d = (state_q == StIdle);
    cnt_d     = (auto_run && (state_d == StIdle)) ? cnt_q + DWELL_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      target_q    <= '0;
      idx_q       <= '0;
      step_pend_q <= 1'b0;
      cfg_pend_q  <= 1'b0;
      cnt_q       <= '0;
      settled_q   <= 1'b1;
      upd_valid_q <= 1'b0;
      frq_q       <= '0;
      ph_q        <= '0;
      amp_q       <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      idx_q       <= idx_d;
      step_pend_q <= step_pend_d;
      cfg_pend_q  <= cfg_pend_d;
      cnt_q       <= cnt_d;
      settled_q   <= settled_d;
      upd_valid_q <= upd_valid_d;
      frq_q       <= frq_d;
      ph_q        <= ph_d;
      amp_q       <= amp_d;
    end
  end

  assign frq_o     = frq_q;
  assign ph_o      = ph_q;
  assign amp_o     = amp_q;
  assign upd_valid = upd_valid_q;
  assign idx_o     = idx_q;

endmodule
